// File: rtl/ext_trig_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : ext_trig_conditioner_if
// Brief    : Trigger-pin, configuration and status bundle for ext_trig_conditioner.
// Revision : 1.0
// ============================================================================
interface ext_trig_conditioner_if #(
  parameter int DEB_W = 20,
  parameter int HO_W  = 32,
  parameter int CNT_W = 32
);
  logic             trig_i;
  logic             enable_i;
  logic             cfg_act_lvl_i;
  logic [DEB_W-1:0] cfg_deb_i;
  logic [HO_W-1:0]  cfg_holdoff_i;
  logic             cnt_clr_i;
  logic             trig_o;
  logic             trig_lvl_o;
  logic             busy_o;
  logic [CNT_W-1:0] trig_cnt_o;

  modport master (
    output trig_i, enable_i, cfg_act_lvl_i, cfg_deb_i, cfg_holdoff_i, cnt_clr_i,
    input  trig_o, trig_lvl_o, busy_o, trig_cnt_o
  );

  modport slave (
    input  trig_i, enable_i, cfg_act_lvl_i, cfg_deb_i, cfg_holdoff_i, cnt_clr_i,
    output trig_o, trig_lvl_o, busy_o, trig_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/ext_trig_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : ext_trig_conditioner
// Brief    : Synchronise, debounce and edge-qualify the external trigger pin,
//            with hold-off and a trigger event counter.
// Revision : 1.0
// ============================================================================
module ext_trig_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 20,
  parameter int HO_W        = 32,
  parameter int CNT_W       = 32
) (
  input wire adc_clk_i,
  input wire adc_rstn_i,
  ext_trig_conditioner_if.slave bus
);

  localparam logic [DEB_W-1:0] C_DEB_ONE = DEB_W'(1);
  localparam logic [HO_W-1:0]  C_HO_ONE  = HO_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic [DEB_W-1:0]       r_deb_cnt;
  logic                   r_lvl;
  logic                   r_lvl_d;
  logic                   r_armed;
  state_t                 r_state;
  logic [HO_W-1:0]        r_ho_cnt;
  logic                   r_trig;
  logic                   r_busy;
  logic [CNT_W-1:0]       r_cnt;

  logic w_vld;
  logic w_n;
  logic w_edge;

  // r_vld marks when the synchroniser output reflects the pin rather than reset zeros.
  assign w_vld  = r_vld[SYNC_STAGES-1];
  assign w_n    = r_sync[SYNC_STAGES-1] ^ ~bus.cfg_act_lvl_i;
  assign w_edge = r_lvl & ~r_lvl_d & r_armed;

  // A pin already active when reset releases must first go inactive before
  // any edge is honoured; r_armed enforces that.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_sync    <= '0;
      r_vld     <= '0;
      r_deb_cnt <= '0;
      r_lvl     <= 1'b0;
      r_lvl_d   <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.trig_i};
      r_vld   <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_lvl_d <= r_lvl;
      if (w_vld && !w_n) begin
        r_armed <= 1'b1;
      end
      if (!w_vld || (w_n == r_lvl)) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt < bus.cfg_deb_i) begin
        r_deb_cnt <= r_deb_cnt + C_DEB_ONE;
      end else begin
        r_lvl     <= ~r_lvl;
        r_deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      r_state  <= ST_IDLE;
      r_ho_cnt <= '0;
      r_trig   <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_trig <= 1'b0;
      if (bus.cnt_clr_i) begin
        r_cnt <= '0;
      end else if (bus.enable_i && w_edge && (r_state == ST_IDLE)) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end

      if (!bus.enable_i) begin
        r_state  <= ST_IDLE;
        r_ho_cnt <= '0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_edge) begin
              r_trig <= 1'b1;
              if (bus.cfg_holdoff_i != '0) begin
                r_ho_cnt <= bus.cfg_holdoff_i;
                r_state  <= ST_HOLDOFF;
                r_busy   <= 1'b1;
              end
            end
          end
          ST_HOLDOFF: begin
            if (r_ho_cnt <= C_HO_ONE) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ho_cnt <= r_ho_cnt - C_HO_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.trig_o     = r_trig;
  assign bus.trig_lvl_o = r_lvl;
  assign bus.busy_o     = r_busy;
  assign bus.trig_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ext_trig_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_trig_conditioner
// Brief    : Directed vector table plus hand sequences for ext_trig_conditioner.
// Revision : 1.0
// ============================================================================
module tb_ext_trig_conditioner;

  localparam int SYNC_STAGES = 2;
  localparam int DEB_W       = 20;
  localparam int HO_W        = 32;
  localparam int CNT_W       = 4;

  typedef struct {
    int deb;
    int len;
    int exp_n;
    int exp_lat;
    int exp_lvl_mid;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   total = 0;
  int   bad   = 0;
  int   busy_cyc = 0;
  int   dbl = 0;
  logic prev_trig = 1'b0;
  int   pulses[$];
  vec_t vecs[7];

  ext_trig_conditioner_if #(.DEB_W(DEB_W), .HO_W(HO_W), .CNT_W(CNT_W)) bus ();

  ext_trig_conditioner #(
    .SYNC_STAGES(SYNC_STAGES), .DEB_W(DEB_W), .HO_W(HO_W), .CNT_W(CNT_W)
  ) dut (
    .adc_clk_i (clk),
    .adc_rstn_i(rstn),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.trig_o) pulses.push_back(cyc);
    if (bus.trig_o && prev_trig) dbl++;
    prev_trig = bus.trig_o;
    if (bus.busy_o) busy_cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: act=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    step(2);
    check("rst_trig_o", bus.trig_o, 0);
    check("rst_lvl", bus.trig_lvl_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_cnt", bus.trig_cnt_o, 0);
    rstn = 1'b1;
    step(6);
    pulses.delete();
  endtask

  task automatic one_trigger();
    bus.trig_i = 1'b1;
    step(6);
    bus.trig_i = 1'b0;
    step(6);
  endtask

  initial begin
    int t0;
    vecs[0] = '{deb: 0, len: 10, exp_n: 1, exp_lat: 4, exp_lvl_mid: 1};
    vecs[1] = '{deb: 5, len: 3,  exp_n: 0, exp_lat: 0, exp_lvl_mid: 0};
    vecs[2] = '{deb: 5, len: 5,  exp_n: 0, exp_lat: 0, exp_lvl_mid: 0};
    vecs[3] = '{deb: 5, len: 6,  exp_n: 1, exp_lat: 9, exp_lvl_mid: 0};
    vecs[4] = '{deb: 2, len: 3,  exp_n: 1, exp_lat: 6, exp_lvl_mid: 0};
    vecs[5] = '{deb: 2, len: 2,  exp_n: 0, exp_lat: 0, exp_lvl_mid: 0};
    vecs[6] = '{deb: 1, len: 8,  exp_n: 1, exp_lat: 5, exp_lvl_mid: 1};

    bus.trig_i        = 1'b0;
    bus.enable_i      = 1'b1;
    bus.cfg_act_lvl_i = 1'b1;
    bus.cfg_deb_i     = '0;
    bus.cfg_holdoff_i = '0;
    bus.cnt_clr_i     = 1'b0;

    // Debounce and latency vectors
    for (int i = 0; i < 7; i++) begin
      bus.cfg_deb_i = DEB_W'(vecs[i].deb);
      apply_reset();
      t0 = cyc;
      bus.trig_i = 1'b1;
      step(vecs[i].len);
      check($sformatf("v%0d_lvl_mid", i), bus.trig_lvl_o, vecs[i].exp_lvl_mid);
      bus.trig_i = 1'b0;
      step(40 - vecs[i].len);
      check($sformatf("v%0d_npulse", i), pulses.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0) check($sformatf("v%0d_latency", i), pulses[0] - t0, vecs[i].exp_lat);
      check($sformatf("v%0d_cnt", i), bus.trig_cnt_o, vecs[i].exp_n);
      check($sformatf("v%0d_lvl_end", i), bus.trig_lvl_o, 0);
    end

    // Hold-off against a 40-cycle square wave
    bus.cfg_deb_i     = '0;
    bus.cfg_holdoff_i = 100;
    apply_reset();
    busy_cyc = 0;
    t0 = cyc;
    repeat (10) begin
      bus.trig_i = 1'b1;
      step(20);
      bus.trig_i = 1'b0;
      step(20);
    end
    step(150);
    check("ho_npulse", pulses.size(), 4);
    check("ho_first_lat", pulses[0] - t0, 4);
    for (int i = 1; i < pulses.size(); i++) check($sformatf("ho_space%0d", i), pulses[i] - pulses[i-1], 120);
    check("ho_busy_cycles", busy_cyc, 400);
    check("ho_cnt", bus.trig_cnt_o, 4);

    // Active-low pin
    bus.cfg_holdoff_i = '0;
    bus.cfg_act_lvl_i = 1'b0;
    bus.trig_i        = 1'b1;
    apply_reset();
    step(10);
    check("al_idle_npulse", pulses.size(), 0);
    check("al_idle_lvl", bus.trig_lvl_o, 0);
    t0 = cyc;
    bus.trig_i = 1'b0;
    step(20);
    check("al_lvl_active", bus.trig_lvl_o, 1);
    check("al_npulse_fall", pulses.size(), 1);
    check("al_latency", pulses[0] - t0, 4);
    bus.trig_i = 1'b1;
    step(30);
    check("al_npulse_rise", pulses.size(), 1);
    check("al_lvl_end", bus.trig_lvl_o, 0);
    check("al_cnt", bus.trig_cnt_o, 1);
    bus.cfg_act_lvl_i = 1'b1;
    bus.trig_i        = 1'b0;

    // Enable gating and counter clear
    bus.enable_i = 1'b0;
    apply_reset();
    bus.trig_i = 1'b1;
    step(10);
    check("en_off_npulse", pulses.size(), 0);
    check("en_off_lvl", bus.trig_lvl_o, 1);
    check("en_off_busy", bus.busy_o, 0);
    bus.enable_i = 1'b1;
    step(10);
    check("en_on_npulse", pulses.size(), 0);
    bus.trig_i = 1'b0;
    step(10);
    bus.trig_i = 1'b1;
    step(10);
    check("en_trig_npulse", pulses.size(), 1);
    check("en_trig_cnt", bus.trig_cnt_o, 1);
    bus.trig_i = 1'b0;
    step(10);
    t0 = cyc;
    bus.trig_i = 1'b1;
    step(3);
    bus.cnt_clr_i = 1'b1;
    step(1);
    bus.cnt_clr_i = 1'b0;
    step(10);
    check("clr_npulse", pulses.size(), 2);
    check("clr_latency", pulses[1] - t0, 4);
    check("clr_cnt", bus.trig_cnt_o, 0);
    bus.trig_i = 1'b0;
    step(10);

    // Asynchronous reset during hold-off with the pin held active
    bus.cfg_holdoff_i = 100;
    apply_reset();
    bus.trig_i = 1'b1;
    step(20);
    check("rh_busy", bus.busy_o, 1);
    check("rh_npulse", pulses.size(), 1);
    #3 rstn = 1'b0;
    #1;
    check("rh_async_busy", bus.busy_o, 0);
    check("rh_async_lvl", bus.trig_lvl_o, 0);
    check("rh_async_cnt", bus.trig_cnt_o, 0);
    check("rh_async_trig", bus.trig_o, 0);
    step(2);
    #3 rstn = 1'b1;
    pulses.delete();
    step(30);
    check("rh_rel_npulse", pulses.size(), 0);
    check("rh_rel_lvl", bus.trig_lvl_o, 1);
    check("rh_rel_busy", bus.busy_o, 0);
    bus.trig_i = 1'b0;
    step(10);
    t0 = cyc;
    bus.trig_i = 1'b1;
    step(20);
    check("rh_retrig_npulse", pulses.size(), 1);
    check("rh_retrig_latency", pulses[0] - t0, 4);
    check("rh_retrig_cnt", bus.trig_cnt_o, 1);
    bus.trig_i = 1'b0;
    step(120);

    // Counter wrap on a 4-bit counter
    bus.cfg_holdoff_i = '0;
    apply_reset();
    repeat (15) one_trigger();
    check("wrap_cnt15", bus.trig_cnt_o, 15);
    one_trigger();
    check("wrap_cnt0", bus.trig_cnt_o, 0);
    one_trigger();
    check("wrap_cnt1", bus.trig_cnt_o, 1);
    check("wrap_npulse", pulses.size(), 17);

    check("single_cycle_pulses", dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ext_trig_conditioner.md
Name: ext_trig_conditioner

Overview:
Conditions the asynchronous external trigger pin (exp_p_io[0] after the IOBUF) before the oscilloscope and ASG trigger muxes. It synchronises the pin into the ADC clock domain, normalises the active level, and debounces it with a programmable stable-time. It then emits a single-cycle trigger pulse per qualified edge, applies a programmable hold-off, and keeps a free-running trigger counter for housekeeping readback. It sits directly downstream of the GPIO input buffer and upstream of the scope/ASG trigger select.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on trig_i; legal range 2..4.
DEB_W, 20, width of the debounce length configuration.
HO_W, 32, width of the hold-off configuration.
CNT_W, 32, width of the trigger event counter.

Ports:
adc_clk_i  input  1  ADC clock; the only clock of the block.
adc_rstn_i  input  1  asynchronous active-low reset.
trig_i  input  1  raw external trigger pin, asynchronous to adc_clk_i.
enable_i  input  1  block enable; 0 suppresses trig_o and clears hold-off.
cfg_act_lvl_i  input  1  pin active level: 1 = active-high, 0 = active-low.
cfg_deb_i  input  DEB_W  number of extra consecutive stable cycles required before the debounced level changes.
cfg_holdoff_i  input  HO_W  cycles after a trigger during which new edges are ignored.
cnt_clr_i  input  1  synchronous clear of trig_cnt_o.
trig_o  output  1  single-cycle trigger pulse on an active edge.
trig_lvl_o  output  1  debounced, active-high-normalised level.
busy_o  output  1  high while hold-off is running.
trig_cnt_o  output  CNT_W  number of trig_o pulses issued.

Behaviour:
- Reset values (asynchronous, on adc_rstn_i=0): all synchroniser flops 0, debounce counter 0, trig_lvl_o 0, trig_o 0, busy_o 0, trig_cnt_o 0, FSM in IDLE.
- Synchroniser: SYNC_STAGES flops on trig_i. The result is normalised as n = sync XOR ~cfg_act_lvl_i, so n=1 means active.
- Debounce:
  - If n equals trig_lvl_o, the counter is cleared to 0.
  - If n differs and the counter is below cfg_deb_i, the counter increments.
  - If n differs and the counter equals or exceeds cfg_deb_i, trig_lvl_o toggles and the counter clears.
  - cfg_deb_i=0 means trig_lvl_o follows n with 1 cycle delay.
  - Any glitch shorter than cfg_deb_i+1 cycles is absorbed.
- Edge detect: active edge = trig_lvl_o rising (0->1), registered. Latency from the first adc_clk_i edge that samples an active trig_i to trig_o=1 is SYNC_STAGES+cfg_deb_i+2 cycles.
- FSM states:
  - IDLE: on an active edge with enable_i=1, assert trig_o for exactly 1 cycle and increment trig_cnt_o. If cfg_holdoff_i>0, load the hold-off counter with cfg_holdoff_i and go to HOLDOFF; otherwise stay in IDLE.
  - HOLDOFF: busy_o=1. The counter decrements each cycle and edges are ignored, with no pulse and no count. When the counter reaches 1, return to IDLE; busy_o drops in the cycle the FSM is back in IDLE. An edge in that first IDLE cycle is accepted.
  - cfg_holdoff_i is sampled only on load; changes during HOLDOFF do not affect the running count.
- enable_i=0: trig_o forced 0, FSM forced to IDLE (busy_o=0). The synchroniser and debounce keep running, so trig_lvl_o stays valid. An edge occurring while disabled never produces a late pulse after re-enable.
- cfg_act_lvl_i change: treated like a pin change. The debounce re-qualifies, and a resulting 0->1 on trig_lvl_o is a legal trigger.
- trig_cnt_o:
  - Wraps from all-ones to 0.
  - cnt_clr_i has priority over increment in the same cycle, so the result is 0.
- Asynchronous reset mid-hold-off or mid-debounce returns every register to its reset value immediately. No pulse is issued on release.

Test Plan:
- Debounce off: cfg_deb_i=0, cfg_holdoff_i=0, act_lvl=1, trig_i 0->1 held 10 cycles -> trig_o single pulse 4 cycles after first sampling edge, trig_cnt_o=1, trig_lvl_o=1.
- Glitch rejection: cfg_deb_i=5, trig_i high pulses of 3, 5 and 6 cycles -> only the 6-cycle pulse triggers (latency 9 cycles), trig_cnt_o=1.
- Hold-off: cfg_holdoff_i=100, trig_i square wave with 40-cycle period, 400 cycles -> trigger pulses spaced 120 cycles (every third edge), busy_o high exactly 100 cycles after each pulse.
- Active-low: cfg_act_lvl_i=0, trig_i idles 1 and drops to 0 for 20 cycles -> one pulse on the falling pin edge, none on the return to 1.
- Enable/clear: enable_i=0 during an edge -> no pulse, trig_lvl_o still 1. Then enable_i=1 -> no pulse. Then cnt_clr_i coincident with a trigger -> trig_cnt_o=0.
- Reset mid-operation: assert adc_rstn_i=0 during HOLDOFF with trig_i held active, then release -> outputs 0, and no trig_o until trig_i deasserts and re-asserts.
